// File: rtl/tree_pkg.sv
// Shared widths, node constants and walker state encoding for the B-tree search slice.
package tree_pkg;

    localparam int KEY_BITS     = 4;
    localparam int DATA_BITS    = 4;
    localparam int NODE_BITS    = 8;
    localparam int ADDRESS_BITS = 16;
    localparam int NULL_NODE    = 0;
    localparam int STAT_BITS    = 16;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        RESPOND
    } state_t;

    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] value);
        return (value == '1) ? value : value + STAT_BITS'(1);
    endfunction

endpackage

// File: rtl/tree_search_stats.sv
// Hit/miss counters for completed searches; both saturate at all-ones.
module tree_search_stats (
    input  logic        clock,
    input  logic        reset,
    input  logic        hit_inc,
    input  logic        miss_inc,
    output logic [15:0] stat_hits,
    output logic [15:0] stat_misses
);
    import tree_pkg::*;

    logic [STAT_BITS-1:0] hits_q, hits_d;
    logic [STAT_BITS-1:0] misses_q, misses_d;

    always_comb begin
        hits_d   = hits_q;
        misses_d = misses_q;
        if (hit_inc) begin
            hits_d = sat_inc(hits_q);
        end
        if (miss_inc) begin
            misses_d = sat_inc(misses_q);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hits_q   <= '0;
            misses_q <= '0;
        end else begin
            hits_q   <= hits_d;
            misses_q <= misses_d;
        end
    end

    assign stat_hits   = hits_q;
    assign stat_misses = misses_q;

endmodule

// File: rtl/tree_search.sv
// Sequential B-tree walker driving the combinational node-index array one level per cycle.
// Optional hit/miss statistics are built when TREE_SEARCH_STATS_EN is defined.
module tree_search #(
    parameter int KEY_BITS     = tree_pkg::KEY_BITS,
    parameter int DATA_BITS    = tree_pkg::DATA_BITS,
    parameter int NODE_BITS    = tree_pkg::NODE_BITS,
    parameter int ADDRESS_BITS = tree_pkg::ADDRESS_BITS,
    parameter int ROOT         = 1,
    parameter int MAX_DEPTH    = 8
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic [KEY_BITS-1:0]              req_key,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic                             rsp_found,
    output logic [DATA_BITS-1:0]             rsp_data,
    output logic                             rsp_overflow,
    output logic [$clog2(MAX_DEPTH+1)-1:0]   rsp_depth,
    output logic [KEY_BITS-1:0]              idx_key,
    output logic [ADDRESS_BITS-1:0]          idx_address,
    input  logic                             idx_found,
    input  logic [DATA_BITS-1:0]             idx_data,
    input  logic [NODE_BITS-1:0]             idx_node,
    output logic [15:0]                      stat_hits,
    output logic [15:0]                      stat_misses
);
    import tree_pkg::*;

    localparam int DEPTH_BITS = $clog2(MAX_DEPTH + 1);

    state_t                  state_q, state_d;
    logic                    req_ready_q, req_ready_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    rsp_found_q, rsp_found_d;
    logic [DATA_BITS-1:0]    rsp_data_q, rsp_data_d;
    logic                    rsp_overflow_q, rsp_overflow_d;
    logic [DEPTH_BITS-1:0]   rsp_depth_q, rsp_depth_d;
    logic [KEY_BITS-1:0]     idx_key_q, idx_key_d;
    logic [ADDRESS_BITS-1:0] idx_address_q, idx_address_d;
    logic [DEPTH_BITS-1:0]   depth_q, depth_d;
    logic [DEPTH_BITS-1:0]   depth_inc;
    logic                    null_child;
    logic                    at_limit;

    assign depth_inc  = depth_q + DEPTH_BITS'(1);
    assign null_child = (idx_node == NODE_BITS'(NULL_NODE));
    assign at_limit   = (depth_inc == DEPTH_BITS'(MAX_DEPTH));

    always_comb begin
        state_d        = state_q;
        req_ready_d    = req_ready_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_found_d    = rsp_found_q;
        rsp_data_d     = rsp_data_q;
        rsp_overflow_d = rsp_overflow_q;
        rsp_depth_d    = rsp_depth_q;
        idx_key_d      = idx_key_q;
        idx_address_d  = idx_address_q;
        depth_d        = depth_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d       = SEARCH;
                    req_ready_d   = 1'b0;
                    idx_key_d     = req_key;
                    idx_address_d = ADDRESS_BITS'(ROOT);
                    depth_d       = '0;
                end
            end
            SEARCH: begin
                depth_d = depth_inc;
                // A hit wins over a null child and over the depth limit in the same cycle.
                if (idx_found || null_child || at_limit) begin
                    state_d        = RESPOND;
                    rsp_valid_d    = 1'b1;
                    rsp_found_d    = idx_found;
                    rsp_data_d     = idx_found ? idx_data : '0;
                    rsp_overflow_d = !idx_found && !null_child;
                    rsp_depth_d    = depth_inc;
                    idx_key_d      = '0;
                    idx_address_d  = '0;
                end else begin
                    idx_address_d = ADDRESS_BITS'(idx_node);
                end
            end
            RESPOND: begin
                if (rsp_ready) begin
                    state_d        = IDLE;
                    req_ready_d    = 1'b1;
                    rsp_valid_d    = 1'b0;
                    rsp_found_d    = 1'b0;
                    rsp_data_d     = '0;
                    rsp_overflow_d = 1'b0;
                    rsp_depth_d    = '0;
                end
            end
            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            req_ready_q    <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_found_q    <= 1'b0;
            rsp_data_q     <= '0;
            rsp_overflow_q <= 1'b0;
            rsp_depth_q    <= '0;
            idx_key_q      <= '0;
            idx_address_q  <= '0;
            depth_q        <= '0;
        end else begin
            state_q        <= state_d;
            req_ready_q    <= req_ready_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_found_q    <= rsp_found_d;
            rsp_data_q     <= rsp_data_d;
            rsp_overflow_q <= rsp_overflow_d;
            rsp_depth_q    <= rsp_depth_d;
            idx_key_q      <= idx_key_d;
            idx_address_q  <= idx_address_d;
            depth_q        <= depth_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_found    = rsp_found_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_overflow = rsp_overflow_q;
    assign rsp_depth    = rsp_depth_q;
    assign idx_key      = idx_key_q;
    assign idx_address  = idx_address_q;

`ifdef TREE_SEARCH_STATS_EN
    logic rsp_fire;
    assign rsp_fire = rsp_valid_q && rsp_ready;

    tree_search_stats u_stats (
        .clock      (clock),
        .reset      (reset),
        .hit_inc    (rsp_fire && rsp_found_q),
        .miss_inc   (rsp_fire && !rsp_found_q),
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
    );
`else
    assign stat_hits   = '0;
    assign stat_misses = '0;
`endif

endmodule
